// File: rtl/cell_pixel_serializer_if.sv
// Stream bundle between the ALU stage, the serializer and the pixel sink.
// Cell side: valid/ready/216-bit cell. Pixel side: valid/ready/24-bit pixel
// plus last-of-cell and last-of-frame markers; busy reports a held cell.
interface cell_pixel_serializer_if;
    logic         cell_valid;
    logic         cell_ready;
    logic [215:0] cell_data;
    logic         pix_valid;
    logic         pix_ready;
    logic [23:0]  pix_data;
    logic         pix_last;
    logic         pix_frame_end;
    logic         busy;

    // Serializer side
    modport slave (
        input  cell_valid,
        input  cell_data,
        input  pix_ready,
        output cell_ready,
        output pix_valid,
        output pix_data,
        output pix_last,
        output pix_frame_end,
        output busy
    );

    // Upstream producer / downstream consumer side
    modport master (
        output cell_valid,
        output cell_data,
        output pix_ready,
        input  cell_ready,
        input  pix_valid,
        input  pix_data,
        input  pix_last,
        input  pix_frame_end,
        input  busy
    );
endinterface

// File: rtl/cell_pixel_serializer.sv
// Output unpacker: takes one 3x3 cell (9 x 24-bit pixels) and emits
// its pixels in order k=0..8, marking last-of-cell and last-of-frame.
// Ports:
//   i_clk   - clock, rising edge
//   i_rst   - asynchronous active-high reset
//   i_abort - synchronous flush of the held cell and the frame count
//   bus     - slave side of cell_pixel_serializer_if
module cell_pixel_serializer #(
    parameter int unsigned CELLS_PER_FRAME = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_abort,
    cell_pixel_serializer_if.slave bus
);

    localparam int unsigned NPIX   = 9;
    localparam int unsigned PIX_W  = 24;
    localparam int unsigned CELL_W = NPIX * PIX_W;

    localparam logic [3:0]  K_LAST     = 4'd8;
    localparam logic [15:0] FRAME_LAST = 16'(CELLS_PER_FRAME - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CELL_W-1:0] r_buf;
    logic [CELL_W-1:0] w_buf_nxt;
    logic [3:0]        r_k;
    logic [3:0]        w_k_nxt;
    logic [15:0]       r_frame_cnt;
    logic [15:0]       w_frame_cnt_nxt;

    logic              w_shift;
    logic              w_at_last;
    logic              w_cell_ready;
    logic              w_cell_fire;
    logic              w_pix_fire;
    logic [PIX_W-1:0]  w_sel;

    assign w_shift   = (r_state == S_SHIFT);
    assign w_at_last = w_shift && (r_k == K_LAST);

    // Ready also opens on the last pixel's handshake so a waiting cell
    // follows without a bubble; this makes pix_ready -> cell_ready
    // combinational. Abort and reset both close the door.
    assign w_cell_ready = !i_rst && !i_abort &&
                          (!w_shift || (w_at_last && bus.pix_ready));
    assign w_cell_fire  = w_cell_ready && bus.cell_valid;
    assign w_pix_fire   = w_shift && bus.pix_ready;

    // Pixel select out of the held cell
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < int'(NPIX); i++) begin
            if (r_k == 4'(i)) begin
                w_sel = r_buf[i*PIX_W +: PIX_W];
            end
        end
    end

    // Next-state and datapath updates
    always_comb begin
        w_state_nxt     = r_state;
        w_buf_nxt       = r_buf;
        w_k_nxt         = r_k;
        w_frame_cnt_nxt = r_frame_cnt;

        if (i_abort) begin
            w_state_nxt     = S_IDLE;
            w_k_nxt         = '0;
            w_frame_cnt_nxt = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_cell_fire) begin
                        w_buf_nxt   = bus.cell_data;
                        w_k_nxt     = '0;
                        w_state_nxt = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_pix_fire) begin
                        if (!w_at_last) begin
                            w_k_nxt = r_k + 4'd1;
                        end else begin
                            w_frame_cnt_nxt = (r_frame_cnt == FRAME_LAST) ?
                                              16'd0 : r_frame_cnt + 16'd1;
                            w_k_nxt = '0;
                            if (w_cell_fire) begin
                                w_buf_nxt   = bus.cell_data;
                                w_state_nxt = S_SHIFT;
                            end else begin
                                w_state_nxt = S_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_buf       <= '0;
            r_k         <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_buf       <= w_buf_nxt;
            r_k         <= w_k_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
        end
    end

    assign bus.cell_ready    = w_cell_ready;
    assign bus.pix_valid     = w_shift;
    assign bus.pix_data      = w_shift ? w_sel : '0;
    assign bus.pix_last      = w_at_last;
    assign bus.pix_frame_end = w_at_last && (r_frame_cnt == FRAME_LAST);
    assign bus.busy          = w_shift;

endmodule

// File: tb/tb_cell_pixel_serializer.sv
// Randomized bench for cell_pixel_serializer against a queue-based
// model of the expected pixel stream.
module tb_cell_pixel_serializer;

    localparam int CPF = 4;

    typedef struct {
        logic [23:0] data;
        logic        last;
        logic        fend;
    } pix_t;

    logic i_clk;
    logic i_rst;
    logic i_abort;

    cell_pixel_serializer_if bus ();

    cell_pixel_serializer #(
        .CELLS_PER_FRAME(CPF)
    ) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_abort(i_abort),
        .bus    (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int   n_checks;
    int   n_fail;
    pix_t q[$];
    int   seq;
    int   fe_seen;
    logic have_hold;
    logic [25:0] held;
    logic acc;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [215:0] rand_cell();
        logic [215:0] c;
        c = '0;
        for (int i = 0; i < 9; i++) c[i*24 +: 24] = 24'($urandom);
        return c;
    endfunction

    // Reference: every accepted cell becomes 9 queued pixels; the cell's
    // position in the frame is its acceptance order since reset/abort.
    always @(negedge i_clk) begin
        if (i_rst) begin
            chk("rst_outs", {bus.cell_ready, bus.pix_valid, bus.pix_last,
                bus.pix_frame_end, bus.busy, bus.pix_data}, '0);
            q.delete();
            seq = 0;
            have_hold = 1'b0;
        end else begin
            chk("pix_valid", bus.pix_valid, q.size() != 0);
            chk("busy", bus.busy, q.size() != 0);
            chk("cell_ready", bus.cell_ready, !i_abort &&
                (q.size() == 0 || (q.size() == 1 && bus.pix_ready)));
            if (have_hold)
                chk("stall_hold", {bus.pix_data, bus.pix_last,
                    bus.pix_frame_end}, held);
            have_hold = 1'b0;
            if (i_abort) begin
                q.delete();
                seq = 0;
            end else begin
                if (q.size() != 0) begin
                    chk("pix_data", bus.pix_data, q[0].data);
                    chk("pix_last", bus.pix_last, q[0].last);
                    chk("frame_end", bus.pix_frame_end, q[0].fend);
                    if (bus.pix_valid && bus.pix_ready) begin
                        if (bus.pix_frame_end) fe_seen++;
                        void'(q.pop_front());
                    end else begin
                        have_hold = 1'b1;
                        held = {bus.pix_data, bus.pix_last,
                                bus.pix_frame_end};
                    end
                end
                if (bus.cell_valid && bus.cell_ready) begin
                    for (int k = 0; k < 9; k++) begin
                        pix_t p;
                        p.data = bus.cell_data[k*24 +: 24];
                        p.last = (k == 8);
                        p.fend = (k == 8) && ((seq % CPF) == CPF - 1);
                        q.push_back(p);
                    end
                    seq++;
                end
            end
        end
    end

    // One cycle: note acceptance before the edge, then release inputs
    task automatic step();
        @(negedge i_clk);
        acc = bus.cell_valid && bus.cell_ready;
        @(posedge i_clk);
        #1;
    endtask

    task automatic offer_cells(input int n);
        int got;
        got = 0;
        bus.cell_data = rand_cell();
        bus.cell_valid = 1'b1;
        for (int c = 0; c < 20 * n && got < n; c++) begin
            step();
            if (acc) begin
                got++;
                if (got < n) bus.cell_data = rand_cell();
                else bus.cell_valid = 1'b0;
            end
        end
        chk("offer_timeout", got, n);
        bus.cell_valid = 1'b0;
    endtask

    task automatic wait_qsize(input int n);
        int ok;
        ok = 0;
        for (int c = 0; c < 40 && ok == 0; c++) begin
            step();
            if (acc) bus.cell_valid = 1'b0;
            if (q.size() == n) ok = 1;
        end
        chk("wait_timeout", ok, 1);
    endtask

    int fe0;
    logic [215:0] pat;

    initial begin
        n_checks = 0;
        n_fail = 0;
        seq = 0;
        fe_seen = 0;
        have_hold = 1'b0;
        i_rst = 1'b1;
        i_abort = 1'b0;
        bus.cell_valid = 1'b0;
        bus.cell_data = '0;
        bus.pix_ready = 1'b0;
        #1;
        chk("reset_state", {bus.cell_ready, bus.pix_valid, bus.busy}, '0);
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;

        // Known pattern, full throughput
        for (int k = 0; k < 9; k++)
            pat[k*24 +: 24] = {8'(k), 8'(k + 16), 8'(k + 32)};
        bus.cell_data = pat;
        bus.cell_valid = 1'b1;
        bus.pix_ready = 1'b1;
        repeat (12) begin
            step();
            if (acc) bus.cell_valid = 1'b0;
        end
        chk("t1_drained", q.size(), 0);

        // Back-to-back cells
        offer_cells(2);
        repeat (12) step();
        chk("t2_drained", q.size(), 0);

        // Frame marker over 5 cells from a cleared count
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        fe0 = fe_seen;
        offer_cells(5);
        repeat (12) step();
        chk("t4_fe_count", fe_seen - fe0, 1);

        // Abort at k=5 with a cell waiting
        bus.cell_data = rand_cell();
        bus.cell_valid = 1'b1;
        wait_qsize(4);
        i_abort = 1'b1;
        bus.cell_valid = 1'b1;
        bus.cell_data = rand_cell();
        step();
        i_abort = 1'b0;
        repeat (12) begin
            step();
            if (acc) bus.cell_valid = 1'b0;
        end
        offer_cells(3);
        repeat (12) step();

        // Asynchronous reset at k=4
        bus.cell_data = rand_cell();
        bus.cell_valid = 1'b1;
        wait_qsize(5);
        #2 i_rst = 1'b1;
        #1;
        chk("async_rst", {bus.cell_ready, bus.pix_valid, bus.pix_last,
            bus.pix_frame_end, bus.busy, bus.pix_data}, '0);
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        bus.cell_valid = 1'b0;
        @(negedge i_clk);
        #1 chk("idle_ready", bus.cell_ready, 1'b1);

        // Random traffic with stalls and occasional aborts
        for (int c = 0; c < 3000; c++) begin
            step();
            if (acc || !bus.cell_valid) begin
                bus.cell_valid = ($urandom_range(99) < 60);
                bus.cell_data = rand_cell();
            end
            bus.pix_ready = ($urandom_range(99) < 70);
            i_abort = ($urandom_range(199) == 0);
        end
        i_abort = 1'b0;
        bus.pix_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            step();
            if (acc) bus.cell_valid = 1'b0;
        end
        chk("final_drain", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
